// File: rtl/bcd2_seg_scan.sv
// Two-digit BCD to multiplexed 7-segment scanner.
// Takes one tear-free snapshot per frame, inserts anode dead time, can blank a leading zero, and keeps a sticky invalid-BCD flag.
module bcd2_seg_scan #(
    parameter int DIGIT_CYCLES = 25000,
    parameter int DEAD_CYCLES  = 250
) (
    input  logic       clki,
    input  logic       rs,
    input  logic [3:0] units,
    input  logic [3:0] tens,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err,
    output logic       frame_tick
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] DEAD_LIM = CW'(DEAD_CYCLES);

    logic [CW-1:0] r_cnt;
    logic          r_slot;
    logic [3:0]    r_uQ;
    logic [3:0]    r_tQ;
    logic          r_blzQ;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;
    logic          r_err;
    logic          r_tick;

    logic          w_capture;
    logic [6:0]    w_seg;
    logic [1:0]    w_an;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign w_capture = (r_slot == 1'b0) && (r_cnt == '0);

    // Next display value from the current slot position; a capture edge always sits in dead time.
    always_comb begin
        w_seg = 7'h7F;
        w_an  = 2'b11;
        if (r_cnt >= DEAD_LIM) begin
            if (!r_slot) begin
                w_an  = 2'b10;
                w_seg = enc(r_uQ);
            end else if (!(r_blzQ && (r_tQ == 4'd0))) begin
                w_an  = 2'b01;
                w_seg = enc(r_tQ);
            end
        end
    end

    always_ff @(posedge clki) begin
        if (!rs) begin
            r_cnt  <= '0;
            r_slot <= 1'b0;
            r_uQ   <= 4'd0;
            r_tQ   <= 4'd0;
            r_blzQ <= 1'b0;
            r_seg  <= 7'h7F;
            r_an   <= 2'b11;
            r_err  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            if (r_cnt == LAST_CNT) begin
                r_cnt  <= '0;
                r_slot <= ~r_slot;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_tick <= w_capture;
            if (w_capture) begin
                r_uQ   <= units;
                r_tQ   <= tens;
                r_blzQ <= blank_lz;
                if ((units > 4'd9) || (tens > 4'd9)) begin
                    r_err <= 1'b1;
                end
            end
            r_seg <= w_seg;
            r_an  <= w_an;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign err        = r_err;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_bcd2_seg_scan.sv
// Self-checking bench for bcd2_seg_scan with DIGIT_CYCLES=8, DEAD_CYCLES=2.
// Expected outputs come from a frame-position model driven by the count of edges since reset release.
module tb_bcd2_seg_scan;

    logic       clki = 1'b0;
    logic       rs = 1'b0;
    logic [3:0] units = 4'd0;
    logic [3:0] tens = 4'd0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;
    logic       frame_tick;

    int checks = 0;
    int failures = 0;

    int         n = 0;
    logic [3:0] mU = 4'd0;
    logic [3:0] mT = 4'd0;
    logic       mB = 1'b0;
    logic       mErr = 1'b0;
    logic [6:0] expSeg = 7'h7F;
    logic [1:0] expAn = 2'b11;
    logic       expTick = 1'b0;
    logic       expErr = 1'b0;
    logic [6:0] encTab [16];

    bcd2_seg_scan #(.DIGIT_CYCLES(8), .DEAD_CYCLES(2)) dut (
        .clki(clki), .rs(rs), .units(units), .tens(tens), .blank_lz(blank_lz),
        .seg(seg), .an(an), .err(err), .frame_tick(frame_tick)
    );

    always #5 clki = ~clki;

    // One clock edge; the model sees the frame as 16 positions, 0..7 units slot, 8..15 tens slot.
    task automatic step();
        int p;
        @(posedge clki);
        if (!rs) begin
            n = 0; mU = 4'd0; mT = 4'd0; mB = 1'b0; mErr = 1'b0;
            expSeg = 7'h7F; expAn = 2'b11; expTick = 1'b0; expErr = 1'b0;
        end else begin
            p = n % 16;
            if ((p % 8) < 2) begin
                expSeg = 7'h7F; expAn = 2'b11;
            end else if (p < 8) begin
                expSeg = encTab[mU]; expAn = 2'b10;
            end else if (mB && mT == 4'd0) begin
                expSeg = 7'h7F; expAn = 2'b11;
            end else begin
                expSeg = encTab[mT]; expAn = 2'b01;
            end
            expTick = (p == 0);
            if (p == 0) begin
                mU = units; mT = tens; mB = blank_lz;
                if (units > 4'd9 || tens > 4'd9) mErr = 1'b1;
            end
            expErr = mErr;
            n++;
        end
        @(negedge clki);
    endtask

    task automatic align_frame();
        for (int k = 0; k < 16 && (n % 16) != 0; k++) step();
    endtask

    task automatic test_reset();
        int ticks;
        rs = 1'b0; units = 4'd7; tens = 4'd3; blank_lz = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks += 4;
            if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got %h exp 7f", seg); end
            if (an !== 2'b11) begin failures++; $display("FAIL reset_an got %b exp 11", an); end
            if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b exp 0", err); end
            if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
        end
        rs = 1'b1;
        ticks = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (frame_tick === 1'b1) ticks++;
            checks += 5;
            if (seg !== expSeg) begin failures++; $display("FAIL run_seg n=%0d got %h exp %h", n, seg, expSeg); end
            if (an !== expAn) begin failures++; $display("FAIL run_an n=%0d got %b exp %b", n, an, expAn); end
            if (frame_tick !== expTick) begin failures++; $display("FAIL run_tick n=%0d got %b exp %b", n, frame_tick, expTick); end
            if (err !== expErr) begin failures++; $display("FAIL run_err n=%0d got %b exp %b", n, err, expErr); end
            if (an === 2'b00) begin failures++; $display("FAIL run_overlap n=%0d got 00 exp not 00", n); end
        end
        checks++;
        if (ticks != 2) begin failures++; $display("FAIL tick_period got %0d ticks exp 2 in 32 cycles", ticks); end
    endtask

    task automatic test_tearing();
        align_frame();
        units = 4'd5; tens = 4'd4; blank_lz = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if ((n % 16) == 4) units = 4'd9;
            step();
            checks += 5;
            if (seg !== expSeg) begin failures++; $display("FAIL tear_seg n=%0d got %h exp %h", n, seg, expSeg); end
            if (an !== expAn) begin failures++; $display("FAIL tear_an n=%0d got %b exp %b", n, an, expAn); end
            if (frame_tick !== expTick) begin failures++; $display("FAIL tear_tick n=%0d got %b exp %b", n, frame_tick, expTick); end
            if (err !== expErr) begin failures++; $display("FAIL tear_err n=%0d got %b exp %b", n, err, expErr); end
            if (an === 2'b00) begin failures++; $display("FAIL tear_overlap n=%0d got 00 exp not 00", n); end
        end
    endtask

    task automatic test_leading_zero();
        logic [3:0] uCase [3];
        logic       bCase [3];
        uCase[0] = 4'd8; bCase[0] = 1'b1;
        uCase[1] = 4'd8; bCase[1] = 1'b0;
        uCase[2] = 4'd0; bCase[2] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            align_frame();
            units = uCase[c]; tens = 4'd0; blank_lz = bCase[c];
            for (int i = 0; i < 17; i++) begin
                step();
                checks += 5;
                if (seg !== expSeg) begin failures++; $display("FAIL lz_seg c=%0d n=%0d got %h exp %h", c, n, seg, expSeg); end
                if (an !== expAn) begin failures++; $display("FAIL lz_an c=%0d n=%0d got %b exp %b", c, n, an, expAn); end
                if (frame_tick !== expTick) begin failures++; $display("FAIL lz_tick c=%0d n=%0d got %b exp %b", c, n, frame_tick, expTick); end
                if (err !== expErr) begin failures++; $display("FAIL lz_err c=%0d n=%0d got %b exp %b", c, n, err, expErr); end
                if (an === 2'b00) begin failures++; $display("FAIL lz_overlap c=%0d n=%0d got 00 exp not 00", c, n); end
            end
        end
    endtask

    task automatic test_invalid_bcd();
        align_frame();
        units = 4'hC; tens = 4'd1; blank_lz = 1'b0;
        for (int i = 0; i < 48; i++) begin
            step();
            if (i == 0) units = 4'd2;
            checks += 5;
            if (seg !== expSeg) begin failures++; $display("FAIL bad_seg n=%0d got %h exp %h", n, seg, expSeg); end
            if (an !== expAn) begin failures++; $display("FAIL bad_an n=%0d got %b exp %b", n, an, expAn); end
            if (frame_tick !== expTick) begin failures++; $display("FAIL bad_tick n=%0d got %b exp %b", n, frame_tick, expTick); end
            if (err !== expErr) begin failures++; $display("FAIL bad_err n=%0d got %b exp %b", n, err, expErr); end
            if (an === 2'b00) begin failures++; $display("FAIL bad_overlap n=%0d got 00 exp not 00", n); end
        end
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got %b exp 1", err); end
    endtask

    task automatic test_dead_time();
        align_frame();
        for (int i = 0; i < 64; i++) begin
            units = 4'($urandom_range(0, 9));
            tens = 4'($urandom_range(0, 9));
            blank_lz = 1'($urandom_range(0, 1));
            step();
            checks += 5;
            if (seg !== expSeg) begin failures++; $display("FAIL rnd_seg n=%0d got %h exp %h", n, seg, expSeg); end
            if (an !== expAn) begin failures++; $display("FAIL rnd_an n=%0d got %b exp %b", n, an, expAn); end
            if (frame_tick !== expTick) begin failures++; $display("FAIL rnd_tick n=%0d got %b exp %b", n, frame_tick, expTick); end
            if (err !== expErr) begin failures++; $display("FAIL rnd_err n=%0d got %b exp %b", n, err, expErr); end
            if (an === 2'b00) begin failures++; $display("FAIL rnd_overlap n=%0d got 00 exp not 00", n); end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 16 && (n % 16) != 13; k++) step();
        rs = 1'b0;
        step();
        checks += 3;
        if (seg !== 7'h7F) begin failures++; $display("FAIL mid_seg got %h exp 7f", seg); end
        if (an !== 2'b11) begin failures++; $display("FAIL mid_an got %b exp 11", an); end
        if (err !== 1'b0) begin failures++; $display("FAIL mid_err got %b exp 0", err); end
        step();
        rs = 1'b1; units = 4'd6; tens = 4'd2; blank_lz = 1'b0;
        step();
        checks++;
        if (frame_tick !== 1'b1) begin failures++; $display("FAIL mid_tick got %b exp 1", frame_tick); end
        for (int i = 0; i < 20; i++) begin
            step();
            checks += 5;
            if (seg !== expSeg) begin failures++; $display("FAIL post_seg n=%0d got %h exp %h", n, seg, expSeg); end
            if (an !== expAn) begin failures++; $display("FAIL post_an n=%0d got %b exp %b", n, an, expAn); end
            if (frame_tick !== expTick) begin failures++; $display("FAIL post_tick n=%0d got %b exp %b", n, frame_tick, expTick); end
            if (err !== expErr) begin failures++; $display("FAIL post_err n=%0d got %b exp %b", n, err, expErr); end
            if (an === 2'b00) begin failures++; $display("FAIL post_overlap n=%0d got 00 exp not 00", n); end
        end
    endtask

    initial begin
        encTab[0] = 7'h40; encTab[1] = 7'h79; encTab[2] = 7'h24; encTab[3] = 7'h30;
        encTab[4] = 7'h19; encTab[5] = 7'h12; encTab[6] = 7'h02; encTab[7] = 7'h78;
        encTab[8] = 7'h00; encTab[9] = 7'h10;
        for (int d = 10; d < 16; d++) encTab[d] = 7'h3F;
        test_reset();
        test_tearing();
        test_leading_zero();
        test_invalid_bcd();
        test_dead_time();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
